cnu_stream: RTL and testbench
=============================

Name: cnu_stream

Overview:
- Serial, degree-programmable min-sum check node unit for the LDPC decoder.
- Accepts one variable-to-check message q per cycle over a valid/ready stream. Computes the total sign, min, min2 and min index, then emits one check-to-variable message r per cycle in arrival order.
- Double-banked: the next check row accumulates while the previous row is emitted.
- Sits between the VNU message memory and the r-message write-back path.

Parameters:
- data_w, 8, message width, two's complement.
- D, 8, maximum check-node degree.
- idx_w, 8, index/count width; must satisfy 2^idx_w > D.
- OFFSET, 1, offset magnitude; used only with CNU_OFFSET_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  q message valid.
- in_ready  out  1  unit can accept q.
- in_data  in  data_w  q message.
- in_last  in  1  marks the last q of the current row.
- out_valid  out  1  r message valid.
- out_ready  in  1  downstream accepts r.
- out_data  out  data_w  r message.
- out_last  out  1  marks the last r of the row.
- out_idx  out  idx_w  position of the current r within its row, 0-based.

Behaviour:
- Reset (rst=0, asynchronous): accumulator goes to ACC; emitter goes to IDLE.
  - Counters and sign store are cleared; min and min2 are set to 2^(data_w-1)-1.
  - Outputs: out_valid=0, out_data=0, out_last=0, out_idx=0, in_ready=1.
  - Reset mid-row or mid-emit discards all partial state; no r is produced for the interrupted rows.
- Magnitude: |q| saturates, so -2^(data_w-1) gives 2^(data_w-1)-1. Sign bit = q[data_w-1].
- Accumulator FSM:
  - ACC: in_ready=1. On each transfer (in_valid & in_ready):
    - store the sign at position cnt and cnt++;
    - sgn_tot ^= sign;
    - if mag < min (strict): min2=min, min=mag, min_idx=cnt;
    - else if mag < min2: min2=mag.
    - Ties keep the earliest index.
  - Row end: a transfer with in_last=1, or the D-th transfer (forced last), ends the row.
    - If the emitter is IDLE, or is completing its final r this same cycle, the bank moves to the emitter on the next edge and ACC restarts with reset values.
    - Otherwise go to HOLD.
  - HOLD: in_ready=0. Move the bank and return to ACC in the cycle the emitter finishes its last transfer.
- Emitter FSM:
  - IDLE: out_valid=0.
  - EMIT: out_valid=1 with registered outputs. For position k:
    - mag_k = (k==min_idx) ? min2 : min;
    - sgn_k = sgn_tot ^ sign[k];
    - scaled = (3*mag_k)>>2, computed at data_w+1 bits; the result always fits data_w;
    - out_data = sgn_k ? -scaled : scaled.
  - Outputs advance only on out_ready. out_last=1 when k = row length - 1.
  - After the last transfer, go to IDLE, or load the pending bank directly (back-to-back rows with no bubble).
- Latency and ordering:
  - First r is valid on the cycle after the row's last q is accepted, when the emitter is idle.
  - Sustained throughput is 1 message/cycle.
  - out_data, out_last and out_idx are held stable while out_valid=1 and out_ready=0.
- Degree-1 row: r uses min2 = 2^(data_w-1)-1, so the output is ±((3*(2^(data_w-1)-1))>>2).
- in_data is ignored when in_valid=0. in_last is ignored without a transfer.

Optional Feature:
- Macro: CNU_OFFSET_EN.
- Defined: offset min-sum. scaled = (mag_k > OFFSET) ? mag_k - OFFSET : 0. The 3/4 normalization logic is not built.
- Undefined: normalized (3*mag)>>2 as above. OFFSET is unused.

Test Plan:
- data_w=8, D=8. q = 5,-3,7,2,-9,4,6,8 with in_last on the 8th, out_ready=1 -> r = 1,-1,1,2,-1,1,1,1; first r one cycle after the last q; out_last on the 8th r.
- Tie with degree 3: q = 4,4,-4 with in_last on the 3rd -> min_idx=0, r = -3,-3,3. With CNU_OFFSET_EN and OFFSET=1 -> r = -3,-3,3 (4-1).
- Saturation: q = -128,100 with in_last -> r = 75,-95.
- Back-to-back and backpressure:
  - Stream row A = test 1 then row B = test 3 with no idle cycles, out_ready toggling 1010… -> in_ready=0 after B's last q until A's final r transfers.
  - Outputs stay stable while stalled; order is A then B; nothing lost or duplicated.
- Overflow: 8 q with in_last never asserted -> row forced closed at the 8th; 8 r with out_last on the 8th; 9th q starts a new row.
- Reset mid-emit: assert rst during the 3rd r of row A -> out_valid=0 immediately, in_ready=1; a new row after reset produces correct results with no residue from A.

Source files
------------

// File: rtl/cnu_stream.sv
// rtl/cnu_stream.sv - serial min-sum check node unit with double-banked accumulate/emit (offset min-sum under CNU_OFFSET_EN)
module cnu_stream #(
    parameter int data_w = 8,
    parameter int D      = 8,
    parameter int idx_w  = 8,
    parameter int OFFSET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [data_w-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [data_w-1:0] out_data,
    output logic              out_last,
    output logic [idx_w-1:0]  out_idx
);

    localparam logic [data_w-1:0] MAG_MAX = {1'b0, {(data_w-1){1'b1}}};
    localparam logic [data_w-1:0] MAG_NEG = {1'b1, {(data_w-1){1'b0}}};
    localparam logic [D-1:0]      ONE_D   = {{(D-1){1'b0}}, 1'b1};

    typedef enum logic {ACC, HOLD} acc_t;
    typedef enum logic {IDLE, EMIT} emit_t;

    acc_t  acc_st, acc_nx;
    emit_t em_st, em_nx;

    // accumulating bank
    logic [idx_w-1:0]  cnt, min_idx;
    logic [data_w-1:0] min_v, min2_v;
    logic              sgn_tot;
    logic [D-1:0]      sgn_v;

    // emitting bank
    logic [idx_w-1:0]  e_len, e_min_idx, e_k;
    logic [data_w-1:0] e_min, e_min2;
    logic              e_sgn_tot;
    logic [D-1:0]      e_sgn_v;

    logic [idx_w-1:0]  nxt_cnt, nxt_min_idx;
    logic [data_w-1:0] nxt_min, nxt_min2, q_neg, q_mag;
    logic              nxt_sgn_tot;
    logic [D-1:0]      nxt_sgn_v;
    logic              xfer, row_end, emit_done, load;

    logic [idx_w-1:0]  src_pos, src_len, src_min_idx;
    logic [data_w-1:0] src_min, src_min2, mag_k, scaled, r_data;
    logic              src_sgn_tot, sgn_k, r_last;
    logic [D-1:0]      src_sgn_v;
`ifndef CNU_OFFSET_EN
    logic [data_w:0]   s3;
`endif

    assign in_ready  = (acc_st == ACC);
    assign out_valid = (em_st == EMIT);
    assign out_idx   = e_k;

    always_comb begin
        q_neg       = -in_data;
        q_mag       = in_data[data_w-1] ? ((in_data == MAG_NEG) ? MAG_MAX : q_neg) : in_data;
        xfer        = in_valid & in_ready;
        nxt_cnt     = cnt;
        nxt_min     = min_v;
        nxt_min2    = min2_v;
        nxt_min_idx = min_idx;
        nxt_sgn_tot = sgn_tot;
        nxt_sgn_v   = sgn_v;
        if (xfer) begin
            nxt_cnt     = cnt + 1'b1;
            nxt_sgn_tot = sgn_tot ^ in_data[data_w-1];
            nxt_sgn_v   = sgn_v | ({{(D-1){1'b0}}, in_data[data_w-1]} << cnt);
            if (q_mag < min_v) begin
                nxt_min2    = min_v;
                nxt_min     = q_mag;
                nxt_min_idx = cnt;
            end else if (q_mag < min2_v) begin
                nxt_min2 = q_mag;
            end
        end
        row_end   = xfer & (in_last | (cnt == idx_w'(D - 1)));
        emit_done = (em_st == EMIT) & out_ready & out_last;
        load      = ((acc_st == ACC) & row_end & ((em_st == IDLE) | emit_done)) |
                    ((acc_st == HOLD) & emit_done);
    end

    always_comb begin
        acc_nx = acc_st;
        em_nx  = em_st;
        case (acc_st)
            ACC:     if (row_end && !load) acc_nx = HOLD;
            HOLD:    if (emit_done) acc_nx = ACC;
            default: acc_nx = ACC;
        endcase
        if (load)
            em_nx = EMIT;
        else if (emit_done)
            em_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_st <= ACC;
            em_st  <= IDLE;
        end else begin
            acc_st <= acc_nx;
            em_st  <= em_nx;
        end
    end

    // a handed-off bank restarts accumulation; HOLD simply keeps the finished row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || load) begin
            cnt     <= '0;
            min_idx <= '0;
            min_v   <= MAG_MAX;
            min2_v  <= MAG_MAX;
            sgn_tot <= 1'b0;
            sgn_v   <= '0;
        end else begin
            cnt     <= nxt_cnt;
            min_idx <= nxt_min_idx;
            min_v   <= nxt_min;
            min2_v  <= nxt_min2;
            sgn_tot <= nxt_sgn_tot;
            sgn_v   <= nxt_sgn_v;
        end
    end

    // next registered r: position 0 of the incoming bank, or k+1 of the current one
    always_comb begin
        src_pos     = load ? '0 : e_k + 1'b1;
        src_len     = load ? nxt_cnt : e_len;
        src_min     = load ? nxt_min : e_min;
        src_min2    = load ? nxt_min2 : e_min2;
        src_min_idx = load ? nxt_min_idx : e_min_idx;
        src_sgn_tot = load ? nxt_sgn_tot : e_sgn_tot;
        src_sgn_v   = load ? nxt_sgn_v : e_sgn_v;
        sgn_k       = src_sgn_tot ^ (|(src_sgn_v & (ONE_D << src_pos)));
        mag_k       = (src_pos == src_min_idx) ? src_min2 : src_min;
`ifdef CNU_OFFSET_EN
        scaled      = (mag_k > data_w'(OFFSET)) ? mag_k - data_w'(OFFSET) : '0;
`else
        s3          = ({1'b0, mag_k} << 1) + {1'b0, mag_k};
        scaled      = data_w'(s3 >> 2);
`endif
        r_data      = sgn_k ? -scaled : scaled;
        r_last      = (src_pos == src_len - 1'b1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_len     <= '0;
            e_min_idx <= '0;
            e_k       <= '0;
            e_min     <= MAG_MAX;
            e_min2    <= MAG_MAX;
            e_sgn_tot <= 1'b0;
            e_sgn_v   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            e_len     <= nxt_cnt;
            e_min_idx <= nxt_min_idx;
            e_min     <= nxt_min;
            e_min2    <= nxt_min2;
            e_sgn_tot <= nxt_sgn_tot;
            e_sgn_v   <= nxt_sgn_v;
            e_k       <= '0;
            out_data  <= r_data;
            out_last  <= r_last;
        end else if (em_st == EMIT && out_ready) begin
            if (out_last) begin
                e_k      <= '0;
                out_data <= '0;
                out_last <= 1'b0;
            end else begin
                e_k      <= src_pos;
                out_data <= r_data;
                out_last <= r_last;
            end
        end
    end

endmodule

// File: tb/tb_cnu_stream.sv
// tb/tb_cnu_stream.sv - randomized and directed bench for cnu_stream against a row-level min-sum model
module tb_cnu_stream;

    localparam int W = 8;
    localparam int D = 8;
    localparam int OFFSET = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_valid, out_ready = 1'b1, out_last;
    logic [W-1:0] out_data;
    logic [7:0]   out_idx;

    cnu_stream #(.data_w(W), .D(D), .idx_w(8), .OFFSET(OFFSET)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    typedef struct {int data; int last; int idx;} exp_t;

    int   total = 0, bad = 0;
    int   cur[$];
    exp_t exp_q[$];
    int   obs[$];
    int   obs_last[$];
    int   mode = 0;
    int   cyc = 0, row_end_cyc = 0, first_valid_cyc = 0;
    bit   prev_stall = 0, prev_valid = 0;
    int   pd = 0, pl = 0, pi = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // whole-row reference: min and second-smallest over the row, xor of signs
    task automatic model_row();
        int n, mn, mi, m2, st, mag, sc, s;
        int m[D];
        exp_t e;
        n = cur.size(); mn = 127; mi = 0; m2 = 127; st = 0;
        for (int i = 0; i < n; i++) begin
            m[i] = (cur[i] < 0) ? ((cur[i] == -128) ? 127 : -cur[i]) : cur[i];
            st ^= int'(cur[i] < 0);
        end
        for (int i = 0; i < n; i++) if (m[i] < mn) begin mn = m[i]; mi = i; end
        for (int i = 0; i < n; i++) if (i != mi && m[i] < m2) m2 = m[i];
        for (int k = 0; k < n; k++) begin
            mag = (k == mi) ? m2 : mn;
`ifdef CNU_OFFSET_EN
            sc = (mag > OFFSET) ? mag - OFFSET : 0;
`else
            sc = (3 * mag) / 4;
`endif
            s = st ^ int'(cur[k] < 0);
            e.data = s ? -sc : sc;
            e.last = int'(k == n - 1);
            e.idx  = k;
            exp_q.push_back(e);
        end
        cur.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            cur.delete(); exp_q.delete();
            prev_stall = 0; prev_valid = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", int'($signed(out_data)), pd);
                check("stall_last", int'(out_last), pl);
                check("stall_idx", int'(out_idx), pi);
            end
            if (in_valid && in_ready) begin
                cur.push_back(int'($signed(in_data)));
                if (in_last || cur.size() == D) begin
                    model_row();
                    row_end_cyc = cyc;
                end
            end
            if (out_valid && !prev_valid) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                obs.push_back(int'($signed(out_data)));
                obs_last.push_back(int'(out_last));
                if (exp_q.size() == 0) check("unexpected_r", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("r_data", int'($signed(out_data)), e.data);
                    check("r_last", int'(out_last), e.last);
                    check("r_idx", int'(out_idx), e.idx);
                end
            end
            prev_stall = out_valid && !out_ready;
            pd = int'($signed(out_data)); pl = int'(out_last); pi = int'(out_idx);
            prev_valid = out_valid;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send_q(input int d, input bit l);
        int n = 0;
        in_valid = 1'b1; in_data = W'(d); in_last = l;
        do begin @(negedge clk); n++; end while (!in_ready && n < 200);
        if (n >= 200) check("in_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'($urandom_range(0, 1)); in_data = W'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin @(posedge clk); #1; n++; end
        check("drain_timeout", int'(n < 500), 1);
    endtask

    task automatic check_obs(input string tag, input int n, input int e[10]);
        check({tag, "_count"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++) check($sformatf("%s_r%0d", tag, i), obs[i], e[i]);
    endtask

    initial begin
        int t1[8]  = '{5, -3, 7, 2, -9, 4, 6, 8};
        int e1[10] = '{1, -1, 1, 2, -1, 1, 1, 1, 0, 0};
        int e2[10] = '{-3, -3, 3, 0, 0, 0, 0, 0, 0, 0};
`ifdef CNU_OFFSET_EN
        int e3[10] = '{99, -126, 0, 0, 0, 0, 0, 0, 0, 0};
        int e4[10] = '{1, -1, 1, 2, -1, 1, 1, 1, 99, -126};
        int deg1 = 126;
`else
        int e3[10] = '{75, -95, 0, 0, 0, 0, 0, 0, 0, 0};
        int e4[10] = '{1, -1, 1, 2, -1, 1, 1, 1, 75, -95};
        int deg1 = 95;
`endif
        int n;
        bit done, held;

        repeat (2) @(posedge clk); #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst = 1'b1;
        @(posedge clk); #1;

        // basic row, full throughput
        obs.delete(); obs_last.delete();
        for (int i = 0; i < 8; i++) send_q(t1[i], i == 7);
        wait_drain();
        check_obs("basic", 8, e1);
        check("basic_latency", first_valid_cyc - row_end_cyc, 1);
        for (int i = 0; i < 8 && i < obs_last.size(); i++) check($sformatf("basic_last%0d", i), obs_last[i], int'(i == 7));

        // tie keeps earliest index
        obs.delete();
        send_q(4, 0); send_q(4, 0); send_q(-4, 1);
        wait_drain();
        check_obs("tie", 3, e2);

        // saturation of -128
        obs.delete();
        send_q(-128, 0); send_q(100, 1);
        wait_drain();
        check_obs("sat", 2, e3);

        // back-to-back rows under toggling backpressure
        obs.delete();
        mode = 1;
        for (int i = 0; i < 8; i++) send_q(t1[i], i == 7);
        send_q(-128, 0); send_q(100, 1);
        check("b2b_hold", int'(in_ready), 0);
        n = 0; done = 0; held = 1;
        while (!done && n < 100) begin
            @(negedge clk); n++;
            if (out_valid && out_ready && out_last && out_idx == 8'd7) done = 1;
            else if (in_ready) held = 0;
        end
        check("b2b_a_final", int'(done), 1);
        check("b2b_held", int'(held), 1);
        @(posedge clk); #1;
        check("b2b_ready_after", int'(in_ready), 1);
        wait_drain();
        mode = 0;
        check_obs("b2b", 10, e4);

        // forced row end at degree D, then a degree-1 row
        obs.delete(); obs_last.delete();
        for (int i = 0; i < 8; i++) send_q(10 + 7 * i, 0);
        send_q(-7, 1);
        wait_drain();
        check("ovf_count", obs.size(), 9);
        for (int i = 0; i < 9 && i < obs_last.size(); i++) check($sformatf("ovf_last%0d", i), obs_last[i], int'(i == 7 || i == 8));
        if (obs.size() == 9) check("ovf_deg1", obs[8], deg1);

        // reset during the third r
        for (int i = 0; i < 8; i++) send_q(t1[i], i == 7);
        n = 0;
        do begin @(negedge clk); n++; end while (!(out_valid && out_idx == 8'd2) && n < 50);
        check("rst_mid_seen", int'(n < 50), 1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_valid", int'(out_valid), 0);
        check("rst_mid_ready", int'(in_ready), 1);
        check("rst_mid_idx", int'(out_idx), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        obs.delete();
        @(posedge clk); #1;
        send_q(4, 0); send_q(4, 0); send_q(-4, 1);
        wait_drain();
        check_obs("after_rst", 3, e2);

        // random rows, gaps and backpressure
        mode = 2;
        for (int r = 0; r < 40; r++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                int v, g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin @(posedge clk); #1; in_data = W'($urandom); end
                v = ($urandom_range(0, 9) == 0) ? -128 : int'($signed(W'($urandom)));
                send_q(v, (i == len - 1) && !(len == 8 && $urandom_range(0, 1) == 1));
            end
        end
        wait_drain();
        mode = 0;
        check("rand_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
